// File: rtl/conv_feeder_pkg.sv
// conv_feeder_pkg: shared state encoding and phase lengths
// for the 3x3 convolution window feeder.
package conv_feeder_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FILT,
        WIN,
        WAIT,
        WRITE,
        FIN
    } state_t;

    localparam int FILT_WORDS  = 10;
    localparam int WIN_WORDS   = 9;
    localparam int WAIT_CYCLES = 2;
    localparam int READ_LAT    = 1;

    // Filter phase also covers the drain of the last coefficient
    // so the accelerator count can wrap before pixels arrive.
    localparam int FILT_CYCLES = FILT_WORDS + READ_LAT + 1;

endpackage

// File: rtl/conv_addr_gen.sv
// conv_addr_gen: incremental pixel and result address counters
// walking every 3x3 window of an IMG_W x IMG_H image.
module conv_addr_gen
    import conv_feeder_pkg::*;
#(
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              init,
    input  logic              step,
    input  logic              next_win,
    input  logic [ADDR_W-1:0] img_base,
    input  logic [ADDR_W-1:0] res_base,
    output logic [ADDR_W-1:0] pix_addr,
    output logic [ADDR_W-1:0] res_addr,
    output logic              last_word,
    output logic              last_window
);

    localparam int RW = $clog2(IMG_H);
    localparam int CW = $clog2(IMG_W);

    localparam logic [ADDR_W-1:0] ONE       = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] ROW_STEP  = ADDR_W'(IMG_W - 2);
    localparam logic [ADDR_W-1:0] WRAP_STEP = ADDR_W'(3);
    localparam logic [RW-1:0]     R_LAST    = RW'(IMG_H - 3);
    localparam logic [CW-1:0]     C_LAST    = CW'(IMG_W - 3);

    logic [1:0]        i;
    logic [1:0]        j;
    logic [RW-1:0]     r;
    logic [CW-1:0]     c;
    logic [ADDR_W-1:0] win_addr;
    logic [ADDR_W-1:0] win_next;

    // Top-left of the next window: +1 along a row, +3 to hop
    // from the last column of one row to column 0 of the next.
    always_comb begin
        win_next = win_addr + ONE;
        if (c == C_LAST) begin
            win_next = win_addr + WRAP_STEP;
        end
    end

    assign last_word   = (i == 2'd2) && (j == 2'd2);
    assign last_window = (r == R_LAST) && (c == C_LAST);

    // Window position and intra-window counters with their addresses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            i        <= '0;
            j        <= '0;
            r        <= '0;
            c        <= '0;
            win_addr <= '0;
            pix_addr <= '0;
            res_addr <= '0;
        end else if (init) begin
            i        <= '0;
            j        <= '0;
            r        <= '0;
            c        <= '0;
            win_addr <= img_base;
            pix_addr <= img_base;
            res_addr <= res_base;
        end else begin
            if (step) begin
                if (j == 2'd2) begin
                    j        <= '0;
                    i        <= (i == 2'd2) ? 2'd0 : i + 2'd1;
                    pix_addr <= pix_addr + ROW_STEP;
                end else begin
                    j        <= j + 2'd1;
                    pix_addr <= pix_addr + ONE;
                end
            end
            if (next_win) begin
                win_addr <= win_next;
                pix_addr <= win_next;
                res_addr <= res_addr + ONE;
                if (c == C_LAST) begin
                    c <= '0;
                    r <= r + RW'(1);
                end else begin
                    c <= c + CW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/conv_window_feeder.sv
// conv_window_feeder: sequencer feeding the 3x3 convolution accelerator.
// Optional macro CONV_FEEDER_RELU_EN clamps negative results to zero.
module conv_window_feeder
    import conv_feeder_pkg::*;
#(
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              load_filt,
    input  logic [ADDR_W-1:0] filt_base,
    input  logic [ADDR_W-1:0] img_base,
    input  logic [ADDR_W-1:0] res_base,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_read,
    input  logic [31:0]       mem_readdata,
    output logic [31:0]       acc_data,
    output logic              acc_valid,
    output logic              acc_filter,
    input  logic [31:0]       acc_result,
    output logic [ADDR_W-1:0] res_address,
    output logic              res_write,
    output logic [31:0]       res_writedata,
    output logic              busy,
    output logic              done
);

    localparam logic [3:0] FILT_LAST = 4'(FILT_CYCLES - 1);
    localparam logic [3:0] FILT_RDS  = 4'(FILT_WORDS);
    localparam logic       WAIT_LAST = 1'(WAIT_CYCLES - 1);

    state_t            state;
    state_t            state_nxt;
    logic [3:0]        fcnt;
    logic              wcnt;
    logic              init;
    logic              next_win;
    logic              filt_rd;
    logic              win_rd;
    logic [ADDR_W-1:0] pix_addr;
    logic [ADDR_W-1:0] res_addr;
    logic              last_word;
    logic              last_window;
    logic              p_valid;
    logic              p_filt;
    logic              p_zero;
    logic [31:0]       res_value;

    conv_addr_gen #(
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .ADDR_W (ADDR_W)
    ) u_addr (
        .clk         (clk),
        .reset       (reset),
        .init        (init),
        .step        (win_rd),
        .next_win    (next_win),
        .img_base    (img_base),
        .res_base    (res_base),
        .pix_addr    (pix_addr),
        .res_addr    (res_addr),
        .last_word   (last_word),
        .last_window (last_window)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and address-generator controls.
    always_comb begin
        state_nxt = state;
        init      = 1'b0;
        next_win  = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    init      = 1'b1;
                    state_nxt = load_filt ? FILT : WIN;
                end
            end
            FILT: begin
                if (fcnt == FILT_LAST) begin
                    state_nxt = WIN;
                end
            end
            WIN: begin
                if (last_word) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (wcnt == WAIT_LAST) begin
                    state_nxt = WRITE;
                end
            end
            WRITE: begin
                next_win  = 1'b1;
                state_nxt = last_window ? FIN : WIN;
            end
            FIN: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Phase cycle counters for the filter load and result wait.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fcnt <= '0;
            wcnt <= 1'b0;
        end else begin
            fcnt <= (state == FILT) ? fcnt + 4'd1 : 4'd0;
            wcnt <= (state == WAIT) ? wcnt + 1'b1 : 1'b0;
        end
    end

    assign filt_rd = (state == FILT) && (fcnt < FILT_RDS);
    assign win_rd  = (state == WIN);

`ifdef CONV_FEEDER_RELU_EN
    assign res_value = acc_result[31] ? 32'd0 : acc_result;
`else
    assign res_value = acc_result;
`endif

    // Memory, result and status outputs decoded from state.
    always_comb begin
        mem_read      = filt_rd || win_rd;
        mem_address   = '0;
        if (filt_rd) begin
            mem_address = filt_base + ADDR_W'(fcnt);
        end else if (win_rd) begin
            mem_address = pix_addr;
        end
        res_write     = (state == WRITE);
        res_address   = res_write ? res_addr : '0;
        res_writedata = res_write ? res_value : 32'd0;
        busy          = (state == FILT) || (state == WIN) ||
                        (state == WAIT) || (state == WRITE);
        done          = (state == FIN);
    end

    // Read-return stage then registered accelerator word; the
    // filter flag and slot-0 marker travel alongside the read.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            p_valid    <= 1'b0;
            p_filt     <= 1'b0;
            p_zero     <= 1'b0;
            acc_valid  <= 1'b0;
            acc_filter <= 1'b0;
            acc_data   <= '0;
        end else begin
            p_valid    <= mem_read;
            p_filt     <= filt_rd;
            p_zero     <= filt_rd && (fcnt == 4'd0);
            acc_valid  <= p_valid;
            acc_filter <= p_valid && p_filt;
            acc_data   <= (p_valid && !p_zero) ? mem_readdata : 32'd0;
        end
    end

endmodule

// File: tb/tb_conv_window_feeder.sv
// tb_conv_window_feeder: randomized self-checking bench with a memory
// model, a behavioural accelerator and a window-level reference.
`timescale 1ns/1ps
module tb_conv_window_feeder;

    localparam int W    = 4;
    localparam int H    = 4;
    localparam int AW   = 16;
    localparam int NWIN = (W - 2) * (H - 2);

`ifdef CONV_FEEDER_RELU_EN
    localparam logic [31:0] NEG_EXP = 32'h0000_0000;
`else
    localparam logic [31:0] NEG_EXP = 32'hD300_0000;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          load_filt = 1'b0;
    logic [AW-1:0] filt_base = '0;
    logic [AW-1:0] img_base = '0;
    logic [AW-1:0] res_base = '0;
    logic [AW-1:0] mem_address;
    logic          mem_read;
    logic [31:0]   mem_readdata = '0;
    logic [31:0]   acc_data;
    logic          acc_valid;
    logic          acc_filter;
    logic [31:0]   acc_result;
    logic [AW-1:0] res_address;
    logic          res_write;
    logic [31:0]   res_writedata;
    logic          busy;
    logic          done;

    conv_window_feeder #(
        .IMG_W  (W),
        .IMG_H  (H),
        .ADDR_W (AW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .load_filt     (load_filt),
        .filt_base     (filt_base),
        .img_base      (img_base),
        .res_base      (res_base),
        .mem_address   (mem_address),
        .mem_read      (mem_read),
        .mem_readdata  (mem_readdata),
        .acc_data      (acc_data),
        .acc_valid     (acc_valid),
        .acc_filter    (acc_filter),
        .acc_result    (acc_result),
        .res_address   (res_address),
        .res_write     (res_write),
        .res_writedata (res_writedata),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Memory with one-cycle read latency.
    logic [31:0] mem [0:65535];
    always @(posedge clk) begin
        if (mem_read) mem_readdata <= mem[mem_address];
    end

    // Q8.24 signed multiply as the accelerator performs it.
    function automatic logic [31:0] qmul(input logic [31:0] a, input logic [31:0] b);
        longint pa;
        longint pb;
        logic signed [63:0] p;
        pa = longint'($signed(a));
        pb = longint'($signed(b));
        p = pa * pb;
        return p[55:24];
    endfunction

    // Behavioural accelerator: slot 0 advances the count, the next
    // nine filter words are coefficients; nine pixels accumulate and
    // the sum clears in the idle cycle that follows them.
    logic [31:0] a_coef [9];
    int          a_fcnt;
    int          a_pcnt;
    logic [31:0] a_sum;
    assign acc_result = a_sum;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            a_fcnt <= 0;
            a_pcnt <= 0;
            a_sum  <= '0;
        end else if (acc_valid && acc_filter) begin
            if (a_fcnt > 0) a_coef[a_fcnt-1] <= acc_data;
            a_fcnt <= (a_fcnt == 9) ? 0 : a_fcnt + 1;
        end else if (acc_valid) begin
            a_sum  <= a_sum + qmul(a_coef[a_pcnt % 9], acc_data);
            a_pcnt <= a_pcnt + 1;
        end else if (a_pcnt == 9) begin
            a_sum  <= '0;
            a_pcnt <= 0;
        end
    end

    // Bus monitor sampled on the falling edge.
    int            cyc = 0;
    logic [AW-1:0] rd_q [$];
    int            rdc_q [$];
    logic [31:0]   aw_q [$];
    logic          af_q [$];
    logic [AW-1:0] wa_q [$];
    logic [31:0]   wd_q [$];
    int            busy_n;
    int            first_busy;
    int            done_n;
    int            done_cyc;
    always @(negedge clk) begin
        cyc++;
        if (mem_read) begin
            rd_q.push_back(mem_address);
            rdc_q.push_back(cyc);
        end
        if (acc_valid) begin
            aw_q.push_back(acc_data);
            af_q.push_back(acc_filter);
        end
        if (res_write) begin
            wa_q.push_back(res_address);
            wd_q.push_back(res_writedata);
        end
        if (busy) begin
            busy_n++;
            if (first_busy < 0) first_busy = cyc;
        end
        if (done) begin
            done_n++;
            done_cyc = cyc;
        end
    end

    // Reference: coefficients the accelerator should hold.
    logic [31:0] ref_coef [9];

    function automatic logic [31:0] ref_result(input logic [AW-1:0] ib, input int r, input int c);
        logic [31:0]   s;
        logic [AW-1:0] a;
        s = '0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                a = ib + AW'((r + i) * W + c + j);
                s = s + qmul(ref_coef[3*i+j], mem[a]);
            end
        end
`ifdef CONV_FEEDER_RELU_EN
        if (s[31]) s = '0;
`endif
        return s;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic clear_mon();
        rd_q.delete();
        rdc_q.delete();
        aw_q.delete();
        af_q.delete();
        wa_q.delete();
        wd_q.delete();
        busy_n = 0;
        first_busy = -1;
        done_n = 0;
        done_cyc = -1;
    endtask

    task automatic set_filter(input logic [AW-1:0] fb, input int mode);
        mem[fb] = 32'hDEAD_BEEF;
        for (int k = 0; k < 9; k++) begin
            case (mode)
                0: ref_coef[k] = 32'h0100_0000;
                1: ref_coef[k] = 32'hFF00_0000;
                default: ref_coef[k] = $urandom;
            endcase
            mem[fb + AW'(k + 1)] = ref_coef[k];
        end
    endtask

    task automatic set_image(input logic [AW-1:0] ib, input int mode);
        for (int k = 0; k < W * H; k++) begin
            mem[ib + AW'(k)] = (mode == 0) ? (32'(k) << 24) : $urandom;
        end
    endtask

    task automatic run(input logic lf, input logic [AW-1:0] fb,
                       input logic [AW-1:0] ib, input logic [AW-1:0] rb,
                       input int extra_at);
        tick(2);
        clear_mon();
        filt_base = fb;
        img_base  = ib;
        res_base  = rb;
        load_filt = lf;
        start     = 1'b1;
        tick(1);
        start     = 1'b0;
        load_filt = 1'b0;
        for (int k = 0; k < 400 && done_n == 0; k++) begin
            start = (k == extra_at);
            tick(1);
        end
        start = 1'b0;
        checks++;
        if (done_n == 0) begin
            errors++;
            $display("FAIL run_timeout: done never seen within 400 cycles");
            reset = 1'b1;
            tick(2);
            reset = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(3);
        checks++;
        if ({mem_read, mem_address, acc_data, acc_valid, acc_filter,
             res_address, res_write, res_writedata, busy, done} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: some output nonzero, busy=%b mem_read=%b acc_valid=%b",
                     busy, mem_read, acc_valid);
        end
        reset = 1'b0;
        tick(3);
        checks++;
        if ({mem_read, acc_valid, res_write, busy, done} !== 5'b0) begin
            errors++;
            $display("FAIL idle_outputs: got %b want 00000",
                     {mem_read, acc_valid, res_write, busy, done});
        end
    endtask

    task automatic test_filter_load();
        logic [31:0]   exp_w;
        logic [AW-1:0] ea;
        set_filter(16'h0100, 2);
        set_image(16'h0000, 1);
        run(1'b1, 16'h0100, 16'h0000, 16'h0200, -1);
        checks++;
        if (rd_q.size() != 10 + 9 * NWIN || aw_q.size() != 10 + 9 * NWIN) begin
            errors++;
            $display("FAIL filt_counts: reads %0d words %0d want %0d",
                     rd_q.size(), aw_q.size(), 10 + 9 * NWIN);
        end
        for (int k = 0; k < 10; k++) begin
            checks++;
            if (rd_q[k] !== 16'h0100 + AW'(k)) begin
                errors++;
                $display("FAIL filt_addr[%0d]: got %h want %h", k, rd_q[k], 16'h0100 + AW'(k));
            end
            exp_w = (k == 0) ? 32'd0 : ref_coef[k-1];
            checks++;
            if (af_q[k] !== 1'b1 || aw_q[k] !== exp_w) begin
                errors++;
                $display("FAIL filt_word[%0d]: got f=%b %h want f=1 %h", k, af_q[k], aw_q[k], exp_w);
            end
        end
        checks++;
        if (rdc_q[0] !== first_busy || rdc_q[9] - rdc_q[0] !== 9) begin
            errors++;
            $display("FAIL filt_timing: first %0d last %0d busy %0d", rdc_q[0], rdc_q[9], first_busy);
        end
        checks++;
        if (af_q[10] !== 1'b0 || rdc_q[10] - rdc_q[9] !== 3) begin
            errors++;
            $display("FAIL filt_to_win: flag %b gap %0d want 0 3", af_q[10], rdc_q[10] - rdc_q[9]);
        end
        for (int w = 0; w < NWIN; w++) begin
            ea = 16'h0200 + AW'(w);
            exp_w = ref_result(16'h0000, w / (W - 2), w % (W - 2));
            checks++;
            if (wa_q[w] !== ea || wd_q[w] !== exp_w) begin
                errors++;
                $display("FAIL filt_result[%0d]: got %h@%h want %h@%h", w, wd_q[w], wa_q[w], exp_w, ea);
            end
        end
    endtask

    task automatic test_window_addr();
        int            r;
        int            c;
        logic [AW-1:0] ea;
        run(1'b0, 16'h0100, 16'h0000, 16'h0200, -1);
        checks++;
        if (rd_q.size() != 9 * NWIN || af_q.size() != 9 * NWIN || busy_n != 12 * NWIN) begin
            errors++;
            $display("FAIL win_counts: reads %0d words %0d busy %0d", rd_q.size(), af_q.size(), busy_n);
        end
        checks++;
        if (rd_q[0] !== 16'h0000 || rdc_q[0] !== first_busy) begin
            errors++;
            $display("FAIL win_first: got %h@%0d want 0000@%0d", rd_q[0], rdc_q[0], first_busy);
        end
        for (int w = 0; w < NWIN; w++) begin
            r = w / (W - 2);
            c = w % (W - 2);
            for (int k = 0; k < 9; k++) begin
                ea = AW'((r + k / 3) * W + c + k % 3);
                checks++;
                if (rd_q[9*w+k] !== ea || af_q[9*w+k] !== 1'b0) begin
                    errors++;
                    $display("FAIL win_addr[%0d][%0d]: got %h f=%b want %h", w, k, rd_q[9*w+k], af_q[9*w+k], ea);
                end
            end
        end
    endtask

    task automatic test_full_run();
        logic [31:0] exp [4];
        exp = '{32'h2D00_0000, 32'h3600_0000, 32'h5100_0000, 32'h5A00_0000};
        set_filter(16'h0100, 0);
        set_image(16'h0000, 0);
        run(1'b1, 16'h0100, 16'h0000, 16'h0200, -1);
        for (int w = 0; w < 4; w++) begin
            checks++;
            if (wa_q[w] !== 16'h0200 + AW'(w) || wd_q[w] !== exp[w]) begin
                errors++;
                $display("FAIL full_result[%0d]: got %h@%h want %h@%h", w, wd_q[w], wa_q[w], exp[w], 16'h0200 + AW'(w));
            end
        end
        checks++;
        if (busy_n != 60 || done_n != 1 || done_cyc != first_busy + 60) begin
            errors++;
            $display("FAIL full_timing: busy %0d done %0d at +%0d want 60 1 +60",
                     busy_n, done_n, done_cyc - first_busy);
        end
    endtask

    task automatic test_relu();
        set_filter(16'h0100, 1);
        set_image(16'h0000, 0);
        run(1'b1, 16'h0100, 16'h0000, 16'h0200, -1);
        checks++;
        if (wd_q[0] !== NEG_EXP) begin
            errors++;
            $display("FAIL relu_first: got %h want %h", wd_q[0], NEG_EXP);
        end
    endtask

    task automatic test_busy_start();
        run(1'b1, 16'h0100, 16'h0000, 16'h0200, 20);
        tick(4);
        checks++;
        if (wa_q.size() != 4 || busy_n != 60 || done_n != 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_start: writes %0d busy_n %0d done %0d busy %b want 4 60 1 0",
                     wa_q.size(), busy_n, done_n, busy);
        end
    endtask

    task automatic test_rerun_nofilt();
        logic [31:0] exp_w;
        set_image(16'h0300, 1);
        run(1'b0, 16'h0100, 16'h0300, 16'h0500, -1);
        checks++;
        if (rd_q[0] !== 16'h0300 || rdc_q[0] !== first_busy || busy_n != 48) begin
            errors++;
            $display("FAIL rerun_first: got %h@%0d busy %0d want 0300@%0d 48",
                     rd_q[0], rdc_q[0], busy_n, first_busy);
        end
        for (int w = 0; w < NWIN; w++) begin
            exp_w = ref_result(16'h0300, w / (W - 2), w % (W - 2));
            checks++;
            if (wd_q[w] !== exp_w || wa_q[w] !== 16'h0500 + AW'(w)) begin
                errors++;
                $display("FAIL rerun_result[%0d]: got %h@%h want %h", w, wd_q[w], wa_q[w], exp_w);
            end
        end
    endtask

    task automatic test_reset_midrun();
        int nrd;
        logic [31:0] exp [4];
        exp = '{32'h2D00_0000, 32'h3600_0000, 32'h5100_0000, 32'h5A00_0000};
        set_filter(16'h0100, 0);
        set_image(16'h0000, 0);
        tick(2);
        clear_mon();
        filt_base = 16'h0100;
        img_base  = 16'h0000;
        res_base  = 16'h0200;
        load_filt = 1'b1;
        start     = 1'b1;
        tick(1);
        start     = 1'b0;
        load_filt = 1'b0;
        for (int k = 0; k < 100 && rd_q.size() < 15; k++) tick(1);
        checks++;
        if (rd_q.size() != 15) begin
            errors++;
            $display("FAIL midrun_reach: reads %0d want 15", rd_q.size());
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({mem_read, mem_address, acc_data, acc_valid, acc_filter,
             res_address, res_write, res_writedata, busy, done} !== '0) begin
            errors++;
            $display("FAIL midrun_outputs: nonzero after reset, busy=%b mem_read=%b acc_valid=%b",
                     busy, mem_read, acc_valid);
        end
        nrd = rd_q.size();
        tick(20);
        checks++;
        if (wa_q.size() != 0 || rd_q.size() != nrd) begin
            errors++;
            $display("FAIL midrun_quiet: writes %0d reads %0d want 0 %0d", wa_q.size(), rd_q.size(), nrd);
        end
        reset = 1'b0;
        run(1'b1, 16'h0100, 16'h0000, 16'h0200, -1);
        for (int w = 0; w < 4; w++) begin
            checks++;
            if (wd_q[w] !== exp[w] || wa_q[w] !== 16'h0200 + AW'(w)) begin
                errors++;
                $display("FAIL midrun_rerun[%0d]: got %h@%h want %h", w, wd_q[w], wa_q[w], exp[w]);
            end
        end
    endtask

    task automatic test_random();
        logic [AW-1:0] ib;
        logic [AW-1:0] rb;
        logic [31:0]   exp_w;
        for (int it = 0; it < 3; it++) begin
            ib = (it == 0) ? 16'hFFF8 : AW'($urandom_range(16'h1000, 16'hFF00));
            rb = (it == 0) ? 16'hFFFE : AW'($urandom);
            set_filter(16'h0100, 2);
            set_image(ib, 1);
            run(1'b1, 16'h0100, ib, rb, -1);
            for (int w = 0; w < NWIN; w++) begin
                exp_w = ref_result(ib, w / (W - 2), w % (W - 2));
                checks++;
                if (wd_q[w] !== exp_w || wa_q[w] !== rb + AW'(w)) begin
                    errors++;
                    $display("FAIL random[%0d][%0d]: got %h@%h want %h@%h",
                             it, w, wd_q[w], wa_q[w], exp_w, rb + AW'(w));
                end
            end
        end
    endtask

    initial begin
        clear_mon();
        test_reset();
        test_filter_load();
        test_window_addr();
        test_full_run();
        test_relu();
        test_busy_start();
        test_rerun_nofilt();
        test_reset_midrun();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/conv_window_feeder.md
Name: conv_window_feeder

Overview:
- Master-side sequencer that drives the 3x3 convolution accelerator's serial word interface (data, valid, filter flag) and collects its 32-bit result.
- Loads 9 Q8.24 filter coefficients from memory, then walks every valid 3x3 window of an IMG_W x IMG_H image, streaming 9 pixels per window.
- Writes each accelerator result to a result buffer. Sits between the on-chip image/weight RAM and the accelerator; the HPS starts it through a control register.

Parameters:
- IMG_W, 28, image width in words (>=3)
- IMG_H, 28, image height in words (>=3)
- ADDR_W, 16, word-address width of memory and result ports

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; sampled only in IDLE
- load_filt  in  1  sampled with start; 1 = run filter phase first
- filt_base  in  ADDR_W  address of dummy slot; coefficients c0..c8 at filt_base+1..+9
- img_base  in  ADDR_W  address of pixel (0,0), row-major
- res_base  in  ADDR_W  address of result (0,0)
- mem_address  out  ADDR_W  read address
- mem_read  out  1  read strobe; fixed 1-cycle read latency, no stall
- mem_readdata  in  32  read data, valid the cycle after mem_read
- acc_data  out  32  word to accelerator
- acc_valid  out  1  acc_data valid this cycle
- acc_filter  out  1  1 = filter-load word, 0 = pixel word
- acc_result  in  32  accelerator running sum
- res_address  out  ADDR_W  result write address
- res_write  out  1  result write strobe
- res_writedata  out  32  result value
- busy  out  1  high from the cycle after start until done
- done  out  1  one-cycle pulse after the last result write

Behaviour:
- Reset: every output is 0 and the FSM enters IDLE. Reset mid-run aborts immediately, with no further reads or writes. The bench must also reset the accelerator.
- FSM states: IDLE -> (start) FILT if load_filt, else WIN -> WIN -> WAIT -> WRITE -> WIN or FIN -> IDLE.
- start while busy is ignored.
- Pipeline: a read issued in cycle t returns data in t+1. acc_data, acc_valid and acc_filter are registered and presented in t+2. acc_filter travels with its word.
- FILT (10 cycles):
  - Issue reads filt_base+0..filt_base+9, one per cycle.
  - The slot-0 word is forced to 0 on acc_data; it is the accelerator's count-advance word.
  - All 10 words go out with acc_valid=1 and acc_filter=1, back-to-back.
  - WIN does not start until 2 cycles after the last FILT read, so the accelerator's count can wrap.
- WIN (9 cycles):
  - For window (r,c), issue img_base + (r+i)*IMG_W + (c+j) for i, j = 0..2, row-major.
  - Addresses are formed incrementally: +1 within a row, +IMG_W-2 between rows. There is no multiplier.
- WAIT (2 cycles): no reads. The last pixel reaches the accelerator in the 2nd WAIT cycle.
- WRITE (1 cycle):
  - Assert res_write with res_address = res_base + r*(IMG_W-2) + c and res_writedata = acc_result.
  - acc_valid is 0 in this cycle; this is the accelerator's wrap cycle.
- Throughput: 12 cycles per window. Total = [10+2 if load_filt] + 12*(IMG_W-2)*(IMG_H-2).
- Window order and wrap:
  - c advances 0..IMG_W-3, then c returns to 0 and r increments.
  - After r = IMG_H-3, c = IMG_W-3 is written, go to FIN.
- FIN: done=1 for one cycle, busy drops in the same cycle, then return to IDLE.
- Filter state persists in the accelerator, so load_filt=0 reuses the previous coefficients.
- Arithmetic: none on data; all data passes through unchanged. Address counters are ADDR_W bits and wrap modulo 2^ADDR_W.

Optional Feature:
- Macro: CONV_FEEDER_RELU_EN.
- Defined: res_writedata = 0 when acc_result[31]=1, else acc_result. Applied combinationally in WRITE, so latency is unchanged.
- Undefined: acc_result is written unchanged.

Decomposition:
- Package conv_feeder_pkg holds:
  - state enum (IDLE, FILT, WIN, WAIT, WRITE, FIN)
  - FILT_WORDS=10, WIN_WORDS=9, WAIT_CYCLES=2, READ_LAT=1
- Sub-module conv_addr_gen: r/c/i/j counters with incremental pixel and result addresses; it raises last_word and last_window flags.
- FSM and pipeline registers live in the top module.

Test Plan:
- Filter load: IMG_W=IMG_H=4, load_filt=1, filt_base=0x100 -> reads 0x100..0x109 on consecutive cycles. acc_filter=1 on 10 valid words: 0 first, then memory values c0..c8.
- Window addressing: img_base=0 -> the first window reads 0,1,2,4,5,6,8,9,10; the second reads 1,2,3,5,6,7,9,10,11.
- Full run with accelerator model: coefficients all 0x01000000, pixel[k]=k<<24, res_base=0x200 -> writes 0x2D000000, 0x36000000, 0x51000000, 0x5A000000 to 0x200..0x203. done occurs 12+48 cycles after start.
- RELU: coefficients all 0xFF000000 -> first result 0xD3000000 without CONV_FEEDER_RELU_EN, 0x00000000 with it.
- Control edges:
  - Second start pulse while busy is ignored; exactly 4 writes occur.
  - Rerun with load_filt=0: the first mem_read is img_base, 2 cycles after start.
- Reset mid-run: assert reset in the 5th WIN cycle -> all outputs 0 immediately and no res_write. A following start (with the accelerator reset too) reproduces the scenario 3 results.
